slice_arbiter: RTL and testbench
================================

# slice_arbiter

Round-robin time-slice arbiter that shares one resource among `NREQ` requesters, using an internal modulo-N slice counter to bound each grant. Each granted requester holds the resource for at most `slice_len` cycles. The grant ends early if the requester drops its request. The block sits in front of any shared datapath that the counter blocks sequence, and it exports the running slice count and a terminal-count pulse so downstream logic can align to slice boundaries.

## Interface
- `NREQ`, default 4: number of requesters; must be ≥ 2.
- `WIDTH`, default 5: width of the slice counter and of `slice_len`.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, `NREQ`: request per requester. A requester holds its bit high while it wants or uses the resource.
- `slice_len`, input, `WIDTH`: slice modulus N. The value 0 means 2^`WIDTH`. It is sampled only when a grant starts.
- `gnt`, output, `NREQ`: one-hot grant, or all-zero when idle.
- `gnt_id`, output, `$clog2(NREQ)`: index of the current grantee. It holds its last value when idle.
- `busy`, output, 1: high while any grant is active (equals `|gnt`).
- `slice_cnt`, output, `WIDTH`: position within the current slice, 0..N-1.
- `tc`, output, 1: high in the final cycle of a full-length slice.

## Operation
- **Reset values:** `gnt`=0, `gnt_id`=0, `busy`=0, `slice_cnt`=0, `tc`=0, internal `ptr`=0, `len_q`=0, state IDLE.
- **State IDLE:**
  - If `req`≠0 at an edge: select the first set bit scanning circularly from `ptr` (`ptr`, `ptr`+1, … mod `NREQ`).
  - Load `gnt`/`gnt_id` with that requester, set `slice_cnt`=0, latch `len_q`=`slice_len`, and go to GRANT.
  - Otherwise stay in IDLE.
- **State GRANT, each edge:**
  - End condition: `req[gnt_id]`=0 (early release), or `slice_cnt`=N-1 (slice expiry), where N = `len_q`, or 2^`WIDTH` if `len_q`=0.
  - No end condition: `slice_cnt` increments by 1.
  - End condition:
    - Set `ptr`=(`gnt_id`+1) mod `NREQ`.
    - Scan `req` circularly from the new `ptr`. The current grantee is checked last, so it is re-granted only if no other requester is pending.
    - If a requester is found: grant it on this same edge, with no idle cycle between grants. Set `slice_cnt`=0 and re-latch `len_q`.
    - If none is found: go to IDLE and set `gnt`=0. `slice_cnt` returns to 0.
- **`tc`:** decoded from registers only (state=GRANT and `slice_cnt`=N-1); there is no combinational path from inputs.
  - `tc` is asserted even if the grantee releases on that same edge.
  - No `tc` is produced for an early release before N-1.
- **Changes to `slice_len` while in GRANT:** ignored until the next grant start.
- **Requests from non-granted requesters:** never preempt a running slice.
- **Width rule:** `slice_cnt` compares against N-1 computed in `WIDTH` bits. `len_q`=0 gives N-1 = all-ones, so the counter wraps naturally.
- **Reset mid-grant:** all outputs go immediately (asynchronously) to their reset values. `ptr` returns to 0, and any partial slice is discarded.

## Timing
- A request sampled high at edge k in IDLE gives `gnt` high from edge k onward (visible in cycle k+1). Arbitration latency is 1 edge.
- A held request gets exactly N cycles of `gnt`. `tc` is high during the Nth cycle.
- Handover between requesters takes zero bubble cycles. The new `gnt` is visible in the cycle after the old grantee's last cycle.
- Early release: `req[gnt_id]` low at edge e ends the grant at e. The next grantee, or IDLE, is visible from cycle e+1.
- `gnt` is one-hot or zero in every cycle. `busy`==|`gnt` always.

## Test plan
- **Single requester:** reset, then `req`=0001, `slice_len`=3 held.
  - `gnt`=0001 continuously (self re-grant).
  - `slice_cnt` runs 0,1,2,0,1,2.
  - `tc` is high every 3rd cycle.
  - `gnt_id`=0 throughout.
- **Round-robin:** `req`=1111, `slice_len`=2.
  - Grant order is 0,0,1,1,2,2,3,3,0,… cycles, with no gaps.
  - `tc` is high on each second cycle.
  - `gnt` is always one-hot.
- **Early release:** `req`=0011, `slice_len`=5; drop `req[0]` when `slice_cnt`=1.
  - `gnt`=0010 appears next cycle with `slice_cnt`=0.
  - No `tc` is produced for requester 0's slice.
- **Modulus 0 and mid-slice change:** `slice_len`=0 with `WIDTH`=5, `req`=0100.
  - The slice lasts 32 cycles and `tc` fires at `slice_cnt`=31.
  - Changing `slice_len` to 4 mid-slice has no effect until the next grant, which then lasts 4 cycles.
- **Go idle:** `req` goes to 0000 in the middle of the slice.
  - `gnt`=0, `busy`=0, `slice_cnt`=0 next cycle.
  - A later `req`=1000 after a grant to requester 1 is granted 1 edge after it is sampled.
- **Reset mid-grant:** assert `reset` asynchronously while `gnt`=0100 and `slice_cnt`=3.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release with `req`=1111, the first grant goes to requester 0 (`ptr`=0).

Source files
------------

// File: rtl/slice_arbiter.sv
// Round-robin time-slice arbiter: one grant at a time, each bounded to N cycles
// by a modulo-N slice counter, with early release when the grantee drops req.
module slice_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 5,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] slice_len,
  output logic [NREQ-1:0]  gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             busy,
  output logic [WIDTH-1:0] slice_cnt,
  output logic             tc,
  output logic             dbg_grant
);

  // Handshake: a requester raises req[i] and keeps it high while it wants or
  // uses the resource; gnt[i] high means it owns the resource this cycle.
  // Dropping req[i] while granted releases the resource at the next edge.

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_gnt_id;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_len;
  logic [WIDTH-1:0] r_cnt;

  logic [IDW-1:0]   w_next_ptr;
  logic [IDW-1:0]   w_scan_start;
  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_sel;
  logic             w_found;
  logic [WIDTH-1:0] w_last;
  logic             w_expire;
  logic             w_end;

  assign w_next_ptr = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);

  // len 0 wraps to all-ones, so a zero modulus naturally means 2^WIDTH.
  assign w_last   = r_len - WIDTH'(1);
  assign w_expire = (r_cnt == w_last);
  assign w_end    = !req[r_gnt_id] || w_expire;

  // Circular priority scan; descending loop so the smallest offset wins.
  always_comb begin
    w_scan_start = (r_state == S_GRANT) ? w_next_ptr : r_ptr;
    w_found      = 1'b0;
    w_sel        = '0;
    w_sum        = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, w_scan_start} + (IDW + 1)'(i);
      if (w_sum >= (IDW + 1)'(NREQ)) begin
        w_sum = w_sum - (IDW + 1)'(NREQ);
      end
      if (req[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
      r_gnt    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_GRANT;
            r_gnt    <= NREQ'(1) << w_sel;
            r_gnt_id <= w_sel;
            r_cnt    <= '0;
            r_len    <= slice_len;
          end
        end
        S_GRANT: begin
          if (!w_end) begin
            r_cnt <= r_cnt + WIDTH'(1);
          end else begin
            r_ptr <= w_next_ptr;
            r_cnt <= '0;
            if (w_found) begin
              r_gnt    <= NREQ'(1) << w_sel;
              r_gnt_id <= w_sel;
              r_len    <= slice_len;
            end else begin
              r_state <= S_IDLE;
              r_gnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign busy      = |r_gnt;
  assign slice_cnt = r_cnt;
  assign tc        = (r_state == S_GRANT) && w_expire;
  assign dbg_grant = (r_state == S_GRANT);

endmodule

// File: tb/tb_slice_arbiter.sv
// Bench for slice_arbiter: directed phases plus random traffic, all checked
// against an owner/position/length reference model of the round-robin rules.
module tb_slice_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 5;
  localparam int IDW   = $clog2(NREQ);

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [WIDTH-1:0] slice_len;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             busy;
  logic [WIDTH-1:0] slice_cnt;
  logic             tc;
  logic             dbg_grant;

  slice_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .slice_len (slice_len),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .slice_cnt (slice_cnt),
    .tc        (tc),
    .dbg_grant (dbg_grant)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_owner;   // -1 when idle
  int m_ptr;
  int m_pos;
  int m_n;       // slice length in cycles for the current grant
  int m_last_id;
  int tc_seen_owner0;

  int tests = 0;
  int fails = 0;

  function automatic int find_req(logic [NREQ-1:0] r, int start);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(start + i) % NREQ]) return (start + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic int len_of(logic [WIDTH-1:0] l);
    return (l == 0) ? (1 << WIDTH) : int'(l);
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_pos     = 0;
    m_n       = 0;
    m_last_id = 0;
  endtask

  task automatic model_edge();
    int f;
    if (m_owner < 0) begin
      f = find_req(req, m_ptr);
      if (f >= 0) begin
        m_owner = f; m_last_id = f; m_pos = 0; m_n = len_of(slice_len);
      end
    end else if (req[m_owner] && (m_pos != m_n - 1)) begin
      m_pos++;
    end else begin
      m_ptr = (m_owner + 1) % NREQ;
      f = find_req(req, m_ptr);
      m_pos = 0;
      if (f >= 0) begin
        m_owner = f; m_last_id = f; m_n = len_of(slice_len);
      end else begin
        m_owner = -1;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NREQ-1:0] e_gnt;
    e_gnt = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("gnt_id", 32'(gnt_id), 32'(m_last_id));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("slice_cnt", 32'(slice_cnt), 32'(m_pos));
    check("tc", 32'(tc), 32'((m_owner >= 0) && (m_pos == m_n - 1)));
    check("state", 32'(dbg_grant), 32'(m_owner >= 0));
    check("onehot", 32'($onehot0(gnt)), 32'(1));
  endtask

  // One edge: update the model from the inputs seen at the edge, then check.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (m_owner == 0 && m_pos == m_n - 1) tc_seen_owner0++;
    check_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int budget;
    reset     = 1'b1;
    req       = '0;
    slice_len = '0;
    model_reset();
    tc_seen_owner0 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Single requester self re-grant, slice of 3
    req = 4'b0001; slice_len = 5'd3;
    run(12);

    // Round-robin with slices of 2
    req = 4'b1111; slice_len = 5'd2;
    run(18);

    // Early release of requester 0 at slice_cnt 1
    req = 4'b0000;
    run(3);
    req = 4'b0011; slice_len = 5'd5;
    budget = 40;
    while (!(m_owner == 0 && m_pos == 1) && budget > 0) begin
      step(); budget--;
    end
    check("early_wait", 32'(budget > 0), 32'(1));
    tc_seen_owner0 = 0;
    req = 4'b0010;
    step();
    check("early_gnt", 32'(gnt), 32'h2);
    check("early_cnt", 32'(slice_cnt), 32'h0);
    check("early_no_tc", 32'(tc_seen_owner0), 32'h0);
    run(6);

    // Modulus 0 (32 cycles), slice_len changed mid-slice
    req = 4'b0000;
    run(2);
    req = 4'b0100; slice_len = 5'd0;
    run(10);
    slice_len = 5'd4;
    run(32);

    // Go idle mid-slice, then a late request from requester 3
    req = 4'b0010; slice_len = 5'd6;
    run(5);
    req = 4'b0000;
    step();
    check("idle_busy", 32'(busy), 32'h0);
    run(2);
    req = 4'b1000;
    step();
    check("late_gnt", 32'(gnt), 32'h8);
    run(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if ($urandom_range(0, 5) == 0) slice_len = WIDTH'($urandom_range(0, 6));
      step();
    end

    // Reset asynchronously mid-grant with requester 2 at slice_cnt 3
    req = 4'b0000;
    run(2);
    req = 4'b0100; slice_len = 5'd8;
    budget = 40;
    while (!(m_owner == 2 && m_pos == 3) && budget > 0) begin
      step(); budget--;
    end
    check("rst_wait", 32'(budget > 0), 32'(1));
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    req = 4'b1111; slice_len = 5'd2;
    reset = 1'b0;
    step();
    check("post_rst_first", 32'(gnt_id), 32'h0);
    run(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
